// File: rtl/ifu_thr_ready_ctl_if.sv
// Thread-ready controller bus: scheduler/pipeline events in, ready vectors
// and LRU-update information out. The master drives the events; the
// controller is the slave.
interface ifu_thr_ready_ctl_if;
    logic [3:0] thr_en;
    logic [3:0] grant_vec;
    logic       stall_s;
    logic       kill_e;
    logic [3:0] rollback_vec;
    logic [3:0] miss_vec;
    logic [3:0] spec_wake;
    logic [3:0] fill_done;
    logic [3:0] req_vec;
    logic [3:0] spec_vec;
    logic       use_spec;
    logic [3:0] recent_vec;
    logic       load_recent;
    logic       grant_err;

    modport master (
        output thr_en, grant_vec, stall_s, kill_e, rollback_vec,
               miss_vec, spec_wake, fill_done,
        input  req_vec, spec_vec, use_spec, recent_vec, load_recent, grant_err
    );

    modport slave (
        input  thr_en, grant_vec, stall_s, kill_e, rollback_vec,
               miss_vec, spec_wake, fill_done,
        output req_vec, spec_vec, use_spec, recent_vec, load_recent, grant_err
    );
endinterface

// File: rtl/ifu_thr_ready_ctl.sv
// Per-thread readiness tracking for a 4-thread fetch unit, plus S/D/E
// thread tracking that feeds the LRU scheduler's recently-used update.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  HALT  | thread disabled; not eligible for fetch
//  RDY   | thread ready, no outstanding long-latency event
//  WAIT  | thread waiting on a miss, no completion predicted yet
//  SPEC  | miss completion predicted; eligible only speculatively
module ifu_thr_ready_ctl (
    input  logic             clk,
    input  logic             reset,
    ifu_thr_ready_ctl_if.slave bus
);

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RDY  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_SPEC = 2'd3;

    logic [1:0] state_q [4];
    logic [1:0] state_d [4];

    logic       s_v_q, d_v_q, e_v_q;
    logic       s_v_d, d_v_d, e_v_d;
    logic [3:0] s_t_q, d_t_q, e_t_q;
    logic [3:0] s_t_d, d_t_d, e_t_d;
    logic       grant_err_q, grant_err_d;

    logic [3:0] kill_mask;
    logic       grant_multi;
    logic       s_in_v;
    logic [3:0] req_vec_c;
    logic [3:0] spec_vec_c;

    // A thread being rolled back or disabled loses every in-flight entry.
    assign kill_mask   = bus.rollback_vec | ~bus.thr_en;
    assign grant_multi = |(bus.grant_vec & (bus.grant_vec - 4'd1));
    assign s_in_v      = (|bus.grant_vec) & ~grant_multi &
                         ~(|(bus.grant_vec & kill_mask));

    // Thread state register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) state_q[i] <= ST_HALT;
            else       state_q[i] <= state_d[i];
        end
    end

    // Thread next-state: disable overrides, fill completion beats miss.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            if (!bus.thr_en[i]) begin
                state_d[i] = ST_HALT;
            end else begin
                case (state_q[i])
                    ST_HALT: state_d[i] = ST_RDY;
                    ST_RDY:  if (bus.miss_vec[i]) state_d[i] = ST_WAIT;
                    ST_WAIT: begin
                        if (bus.fill_done[i])      state_d[i] = ST_RDY;
                        else if (bus.spec_wake[i]) state_d[i] = ST_SPEC;
                    end
                    ST_SPEC: begin
                        if (bus.fill_done[i])
                            state_d[i] = ST_RDY;
                        else if (bus.miss_vec[i] || bus.rollback_vec[i])
                            state_d[i] = ST_WAIT;
                    end
                    default: state_d[i] = ST_HALT;
                endcase
            end
        end
    end

    // Ready vectors decoded from registered state only.
    always_comb begin
        req_vec_c  = '0;
        spec_vec_c = '0;
        for (int i = 0; i < 4; i++) begin
            req_vec_c[i]  = (state_q[i] == ST_RDY);
            spec_vec_c[i] = (state_q[i] == ST_RDY) || (state_q[i] == ST_SPEC);
        end
    end

    // Stage tracking next-state: shift or hold, then squash killed threads.
    always_comb begin
        if (bus.stall_s) begin
            s_v_d = s_v_q & ~(|(s_t_q & kill_mask));
            d_v_d = d_v_q & ~(|(d_t_q & kill_mask));
            e_v_d = e_v_q & ~(|(e_t_q & kill_mask));
            s_t_d = s_t_q;
            d_t_d = d_t_q;
            e_t_d = e_t_q;
        end else begin
            s_v_d = s_in_v;
            d_v_d = s_v_q & ~(|(s_t_q & kill_mask));
            e_v_d = d_v_q & ~(|(d_t_q & kill_mask));
            s_t_d = grant_multi ? 4'd0 : bus.grant_vec;
            d_t_d = s_t_q;
            e_t_d = d_t_q;
        end
        grant_err_d = grant_err_q | grant_multi;
    end

    // Stage tracking and sticky grant error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_v_q       <= 1'b0;
            d_v_q       <= 1'b0;
            e_v_q       <= 1'b0;
            s_t_q       <= 4'd0;
            d_t_q       <= 4'd0;
            e_t_q       <= 4'd0;
            grant_err_q <= 1'b0;
        end else begin
            s_v_q       <= s_v_d;
            d_v_q       <= d_v_d;
            e_v_q       <= e_v_d;
            s_t_q       <= s_t_d;
            d_t_q       <= d_t_d;
            e_t_q       <= e_t_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign bus.req_vec     = req_vec_c;
    assign bus.spec_vec    = spec_vec_c;
    assign bus.use_spec    = ~(|req_vec_c);
    assign bus.recent_vec  = e_v_q ? e_t_q : 4'd0;
    assign bus.load_recent = e_v_q & ~bus.kill_e & ~bus.stall_s &
                             ~(|(bus.rollback_vec & e_t_q));
    assign bus.grant_err   = grant_err_q;

endmodule

// File: tb/tb_ifu_thr_ready_ctl.sv
module tb_ifu_thr_ready_ctl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ifu_thr_ready_ctl_if ifc ();

    ifu_thr_ready_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.grant_vec    = 4'd0;
        ifc.stall_s      = 1'b0;
        ifc.kill_e       = 1'b0;
        ifc.rollback_vec = 4'd0;
        ifc.miss_vec     = 4'd0;
        ifc.spec_wake    = 4'd0;
        ifc.fill_done    = 4'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ifc.thr_en = 4'b1111;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ifc.req_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_req: got %b exp 0000", ifc.req_vec); end
        n_checks++;
        if (ifc.spec_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_spec: got %b exp 0000", ifc.spec_vec); end
        n_checks++;
        if (ifc.use_spec !== 1'b1) begin n_fail++; $display("FAIL reset_use_spec: got %b exp 1", ifc.use_spec); end
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent, ifc.grant_err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_misc: got recent=%b load=%b err=%b exp 0", ifc.recent_vec, ifc.load_recent, ifc.grant_err);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec, ifc.use_spec} !== 9'b1111_1111_0) begin
            n_fail++; $display("FAIL enable_all: got req=%b spec=%b use=%b exp 1111 1111 0", ifc.req_vec, ifc.spec_vec, ifc.use_spec);
        end
    endtask

    task automatic test_miss_wake_fill();
        ifc.miss_vec = 4'b0010;
        tick();
        ifc.miss_vec = 4'b0000;
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec} !== 8'b1101_1101) begin
            n_fail++; $display("FAIL miss_t1: got req=%b spec=%b exp 1101 1101", ifc.req_vec, ifc.spec_vec);
        end
        ifc.spec_wake = 4'b0011;
        tick();
        ifc.spec_wake = 4'b0000;
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec} !== 8'b1101_1111) begin
            n_fail++; $display("FAIL wake_t1: got req=%b spec=%b exp 1101 1111", ifc.req_vec, ifc.spec_vec);
        end
        ifc.fill_done = 4'b0011;
        tick();
        ifc.fill_done = 4'b0000;
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec} !== 8'b1111_1111) begin
            n_fail++; $display("FAIL fill_t1: got req=%b spec=%b exp 1111 1111", ifc.req_vec, ifc.spec_vec);
        end
        ifc.thr_en = 4'b1011;
        tick();
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec} !== 8'b1011_1011) begin
            n_fail++; $display("FAIL disable_t2: got req=%b spec=%b exp 1011 1011", ifc.req_vec, ifc.spec_vec);
        end
        ifc.thr_en = 4'b1111;
        tick();
        n_checks++;
        if (ifc.req_vec !== 4'b1111) begin n_fail++; $display("FAIL reenable_t2: got %b exp 1111", ifc.req_vec); end
    endtask

    task automatic test_spec_rollback();
        ifc.miss_vec = 4'b1111;
        tick();
        ifc.miss_vec = 4'b0000;
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec, ifc.use_spec} !== 9'b0000_0000_1) begin
            n_fail++; $display("FAIL all_wait: got req=%b spec=%b use=%b exp 0000 0000 1", ifc.req_vec, ifc.spec_vec, ifc.use_spec);
        end
        ifc.spec_wake = 4'b0100;
        tick();
        ifc.spec_wake = 4'b0000;
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec, ifc.use_spec} !== 9'b0000_0100_1) begin
            n_fail++; $display("FAIL t2_spec: got req=%b spec=%b use=%b exp 0000 0100 1", ifc.req_vec, ifc.spec_vec, ifc.use_spec);
        end
        ifc.rollback_vec = 4'b0100;
        tick();
        ifc.rollback_vec = 4'b0000;
        n_checks++;
        if (ifc.spec_vec !== 4'b0000) begin n_fail++; $display("FAIL rollback_spec: got %b exp 0000", ifc.spec_vec); end
        ifc.miss_vec  = 4'b1111;
        ifc.fill_done = 4'b1111;
        tick();
        ifc.miss_vec  = 4'b0000;
        ifc.fill_done = 4'b0000;
        n_checks++;
        if (ifc.req_vec !== 4'b1111) begin n_fail++; $display("FAIL fill_beats_miss: got %b exp 1111", ifc.req_vec); end
    endtask

    task automatic test_pipeline();
        ifc.grant_vec = 4'b0001; tick();
        ifc.grant_vec = 4'b0010; tick();
        ifc.grant_vec = 4'b0100; tick();
        ifc.grant_vec = 4'b0000;
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0001_1) begin
            n_fail++; $display("FAIL e_t0: got recent=%b load=%b exp 0001 1", ifc.recent_vec, ifc.load_recent);
        end
        ifc.kill_e = 1'b1;
        #1;
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0001_0) begin
            n_fail++; $display("FAIL kill_e: got recent=%b load=%b exp 0001 0", ifc.recent_vec, ifc.load_recent);
        end
        ifc.kill_e  = 1'b0;
        ifc.stall_s = 1'b1;
        tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0001_0) begin
            n_fail++; $display("FAIL stall_hold: got recent=%b load=%b exp 0001 0", ifc.recent_vec, ifc.load_recent);
        end
        ifc.stall_s = 1'b0;
        tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0010_1) begin
            n_fail++; $display("FAIL e_t1: got recent=%b load=%b exp 0010 1", ifc.recent_vec, ifc.load_recent);
        end
        tick();
        ifc.rollback_vec = 4'b0100;
        #1;
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0100_0) begin
            n_fail++; $display("FAIL rollback_e: got recent=%b load=%b exp 0100 0", ifc.recent_vec, ifc.load_recent);
        end
        ifc.rollback_vec = 4'b0000;
        tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0000_0) begin
            n_fail++; $display("FAIL e_empty: got recent=%b load=%b exp 0000 0", ifc.recent_vec, ifc.load_recent);
        end
    endtask

    task automatic test_rollback_d();
        ifc.grant_vec = 4'b0010; tick();
        ifc.grant_vec = 4'b0000; tick();
        ifc.rollback_vec = 4'b0010; tick();
        ifc.rollback_vec = 4'b0000;
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0000_0) begin
            n_fail++; $display("FAIL rollback_d: got recent=%b load=%b exp 0000 0", ifc.recent_vec, ifc.load_recent);
        end
        tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent} !== 5'b0000_0) begin
            n_fail++; $display("FAIL rollback_d_later: got recent=%b load=%b exp 0000 0", ifc.recent_vec, ifc.load_recent);
        end
        ifc.grant_vec = 4'b1000; tick();
        ifc.grant_vec = 4'b0000; tick();
        tick();
        n_checks++;
        if (ifc.recent_vec !== 4'b1000) begin n_fail++; $display("FAIL e_t3: got %b exp 1000", ifc.recent_vec); end
        ifc.stall_s = 1'b1;
        ifc.thr_en  = 4'b0111;
        tick();
        ifc.stall_s = 1'b0;
        ifc.thr_en  = 4'b1111;
        n_checks++;
        if (ifc.recent_vec !== 4'b0000) begin n_fail++; $display("FAIL disable_in_stall: got %b exp 0000", ifc.recent_vec); end
        tick();
        tick();
    endtask

    task automatic test_grant_err();
        ifc.miss_vec = 4'b0100;
        tick();
        ifc.miss_vec  = 4'b0000;
        ifc.grant_vec = 4'b0100;
        tick();
        ifc.grant_vec = 4'b0000;
        tick(); tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.spec_vec} !== 8'b0100_1011) begin
            n_fail++; $display("FAIL grant_not_ready: got recent=%b spec=%b exp 0100 1011", ifc.recent_vec, ifc.spec_vec);
        end
        ifc.fill_done = 4'b0100;
        tick();
        ifc.fill_done = 4'b0000;
        tick();
        n_checks++;
        if (ifc.grant_err !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b exp 0", ifc.grant_err); end
        ifc.grant_vec = 4'b0011;
        tick();
        ifc.grant_vec = 4'b0000;
        n_checks++;
        if (ifc.grant_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", ifc.grant_err); end
        tick(); tick();
        n_checks++;
        if ({ifc.recent_vec, ifc.load_recent, ifc.grant_err} !== 6'b0000_0_1) begin
            n_fail++; $display("FAIL multi_dropped: got recent=%b load=%b err=%b exp 0000 0 1", ifc.recent_vec, ifc.load_recent, ifc.grant_err);
        end
        tick();
        n_checks++;
        if (ifc.grant_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", ifc.grant_err); end
    endtask

    task automatic test_reset_midop();
        ifc.grant_vec = 4'b0001; tick();
        ifc.grant_vec = 4'b0010; tick();
        ifc.grant_vec = 4'b0100;
        ifc.miss_vec  = 4'b0001;
        ifc.fill_done = 4'b0010;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        n_checks++;
        if ({ifc.req_vec, ifc.spec_vec, ifc.use_spec, ifc.recent_vec, ifc.load_recent, ifc.grant_err} !== 15'b0000_0000_1_0000_0_0) begin
            n_fail++; $display("FAIL midop_reset: got req=%b spec=%b use=%b recent=%b load=%b err=%b exp 0000 0000 1 0000 0 0",
                ifc.req_vec, ifc.spec_vec, ifc.use_spec, ifc.recent_vec, ifc.load_recent, ifc.grant_err);
        end
        tick();
        tick();
        n_checks++;
        if ({ifc.req_vec, ifc.recent_vec} !== 8'b1111_0000) begin
            n_fail++; $display("FAIL after_reset: got req=%b recent=%b exp 1111 0000", ifc.req_vec, ifc.recent_vec);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        ifc.thr_en = 4'b0000;
        clear_inputs();
        test_reset();
        test_miss_wake_fill();
        test_spec_rollback();
        test_pipeline();
        test_rollback_d();
        test_grant_err();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
